forwarding_hazard_unit: RTL
===========================

// Module: forwarding_hazard_unit
// PURPOSE
//  Produces the 2-bit select codes consumed by the EX-stage operand forwarding muxes (ALU A/B).
//  Tracks destination registers of in-flight instructions in shadow EX, MEM and WB registers.
//  Detects load-use hazards and raises stall, inserting one bubble.
//  Sits beside the ID/EX pipeline register; sees the decode-stage instruction each cycle.
// PARAMETERS
//  REG_AW  5   register-address width (x0..x31)
//  CNT_W   16  width of saturating stall-event counter
// PORTS
//  clk           in   1       pipeline clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  id_valid      in   1       decode-stage slot holds a real instruction
//  id_rs1        in   REG_AW  decode-stage source 1
//  id_rs2        in   REG_AW  decode-stage source 2
//  id_uses_rs1   in   1       instruction actually reads rs1
//  id_uses_rs2   in   1       instruction actually reads rs2 (0 for I-type/LUI/JAL)
//  id_rd         in   REG_AW  decode-stage destination
//  id_reg_write  in   1       instruction writes rd
//  id_mem_read   in   1       instruction is a load
//  flush         in   1       branch/jump taken; instruction leaving ID is squashed
//  fwd_a         out  2       registered select for EX operand A mux
//  fwd_b         out  2       registered select for EX operand B mux
//  stall         out  1       combinational; freeze PC and IF/ID this cycle
//  stall_count   out  CNT_W   number of load-use stall cycles since reset
// BEHAVIOUR
//  Select codes: 00 register file, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
//  Register file is write-first; no WB-to-EX path is needed beyond code 10.
//  Shadow state per stage: {rd, reg_write, mem_read}; reset clears all to 0.
//  Reset: fwd_a=fwd_b=00, stall=0 (forced 0 while rst=1), stall_count=0, shadows cleared.
//  Every cycle: wb <= mem; mem <= ex (the pipeline after EX never stalls).
//  stall = id_valid & ex.mem_read & ex.rd!=0 &
//          ((id_uses_rs1 & ex.rd==id_rs1) | (id_uses_rs2 & ex.rd==id_rs2)).
//  Per operand src (rs1->fwd_a, rs2->fwd_b), next select when ID advances:
//    uses & ex.reg_write & ex.rd!=0 & ex.rd==src   -> 01 (youngest producer wins)
//    else uses & mem.reg_write & mem.rd!=0 & mem.rd==src -> 10
//    else -> 00
//  Advance (stall=0, flush=0): ex <= {id_rd, id_reg_write&id_valid, id_mem_read&id_valid};
//    fwd_a/fwd_b <= computed next selects.
//  Bubble (stall=1 or flush=1 or id_valid=0): ex <= 0; fwd_a=fwd_b <= 00.
//  flush has priority over stall; flush and stall in the same cycle still counts the stall.
//  stall_count increments on each stall=1 cycle; saturates at all-ones, never wraps.
//  Latency: a load-use pair costs exactly 1 bubble; the dependent instruction then gets 10.
//  rd=x0 never forwards and never stalls, regardless of reg_write.
//  rst asserted mid-stall: next cycle all state is reset; stall deasserts immediately.
// STRUCTURE
//  Shared package fwd_pkg: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, REG_AW default.
//  Sub-module fwd_src_select: one operand's priority compare (src, uses, ex/mem shadows -> 2-bit);
//    instantiated twice (rs1, rs2).
//  Top holds the shadow registers, stall logic, output registers and counter.
// TESTING
//  add x5,x1,x2 then add x6,x5,x3 -> fwd_a=01, fwd_b=00 in EX of second; stall never 1.
//  add x5,.. ; nop ; sub x7,x4,x5 -> fwd_b=10, fwd_a=00.
//  lw x5,0(x1) then add x6,x5,x5 -> stall=1 one cycle, bubble (fwd 00), then fwd_a=fwd_b=10;
//    stall_count=1.
//  lw x5 then addi x6,x7,4 with id_rs2=5, id_uses_rs2=0 -> no stall, fwd_a=fwd_b=00.
//  add x5 ; add x5 ; add x6,x5,x5 -> both selects 01 (youngest wins over MEM 10).
//  add x0,x1,x2 then add x6,x0,x0 -> fwd 00; lw x5 + dependent with flush=1 -> bubble, then
//    rst held 1 cycle mid-stall -> fwd 00, stall 0, stall_count 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared select encodings and default widths for the EX-stage operand forwarding logic.
package fwd_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   localparam int FWD_REG_AW = 5;

endpackage

// File: rtl/fwd_src_select.sv
// Priority compare for one source operand: the youngest in-flight producer wins.
module fwd_src_select
   import fwd_pkg::*;
#(
   parameter int REG_AW = FWD_REG_AW
) (
   input  logic [REG_AW-1:0] src,
   input  logic              uses,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_write,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_RF;
      if (uses && ex_reg_write && (ex_rd != '0) && (ex_rd == src)) begin
         sel = FWD_EXMEM;
      end else if (uses && mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// EX-stage forwarding select generation and load-use stall detection, tracking
// the destinations of instructions currently in EX and MEM.
module forwarding_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_AW = FWD_REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   // The register file is write-first, so nothing downstream of MEM can
   // influence a select; the WB shadow would never be read.
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic              ex_rw_q, ex_rw_d;
   logic              ex_mr_q, ex_mr_d;
   logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
   logic              mem_rw_q, mem_rw_d;
   logic [1:0]        fwd_a_q, fwd_a_d;
   logic [1:0]        fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0]  stall_count_q, stall_count_d;
   logic [1:0]        sel_a, sel_b;
   logic              advance;

   fwd_src_select #(.REG_AW(REG_AW)) u_sel_a (
      .src           (id_rs1),
      .uses          (id_uses_rs1),
      .ex_rd         (ex_rd_q),
      .ex_reg_write  (ex_rw_q),
      .mem_rd        (mem_rd_q),
      .mem_reg_write (mem_rw_q),
      .sel           (sel_a)
   );

   fwd_src_select #(.REG_AW(REG_AW)) u_sel_b (
      .src           (id_rs2),
      .uses          (id_uses_rs2),
      .ex_rd         (ex_rd_q),
      .ex_reg_write  (ex_rw_q),
      .mem_rd        (mem_rd_q),
      .mem_reg_write (mem_rw_q),
      .sel           (sel_b)
   );

   always_comb begin
      stall = !rst && id_valid && ex_mr_q && (ex_rd_q != '0) &&
              ((id_uses_rs1 && (ex_rd_q == id_rs1)) ||
               (id_uses_rs2 && (ex_rd_q == id_rs2)));
      // A stalled, flushed or empty slot enters EX as a bubble.
      advance = id_valid && !stall && !flush;

      ex_rd_d  = advance ? id_rd : '0;
      ex_rw_d  = advance && id_reg_write;
      ex_mr_d  = advance && id_mem_read;
      mem_rd_d = ex_rd_q;
      mem_rw_d = ex_rw_q;
      fwd_a_d  = advance ? sel_a : FWD_RF;
      fwd_b_d  = advance ? sel_b : FWD_RF;

      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_rd_q       <= '0;
         ex_rw_q       <= 1'b0;
         ex_mr_q       <= 1'b0;
         mem_rd_q      <= '0;
         mem_rw_q      <= 1'b0;
         fwd_a_q       <= FWD_RF;
         fwd_b_q       <= FWD_RF;
         stall_count_q <= '0;
      end else begin
         ex_rd_q       <= ex_rd_d;
         ex_rw_q       <= ex_rw_d;
         ex_mr_q       <= ex_mr_d;
         mem_rd_q      <= mem_rd_d;
         mem_rw_q      <= mem_rw_d;
         fwd_a_q       <= fwd_a_d;
         fwd_b_q       <= fwd_b_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign fwd_a       = fwd_a_q;
   assign fwd_b       = fwd_b_q;
   assign stall_count = stall_count_q;

endmodule
